pixart_i2c_target: RTL and testbench

- I2C responder (slave) emulating the PixArt IR camera at 7-bit address 0x58; the far end of the `camera` I2C initiator.
- Used in simulation and on a second board, so `camera`/`xy_leds` and the sram drawing path can run without a real sensor.
- Accepts configuration writes from the initiator and returns a 16-byte blob report built from `blob_x`/`blob_y`.
- Oversamples SCL/SDA in the system clock domain. SDA is open-drain: drive low or release.

---
 rtl/pixart_pkg.sv | 54 +++++
 rtl/i2c_line_filter.sv | 71 +++++++
 rtl/pixart_i2c_target.sv | 219 +++++++++++++++++++++
 tb/tb_pixart_i2c_target.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixart_pkg.sv
// Shared definitions for the PixArt IR camera I2C emulation: address, report layout and FSM encoding.
package pixart_pkg;

  localparam logic [6:0] DEFAULT_ADDR = 7'h58;
  localparam int         REPORT_LEN   = 16;
  localparam int         IDX_W        = $clog2(REPORT_LEN);
  localparam logic [7:0] NO_BLOB      = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_PTR      = 3'd3,
    ST_WR_BYTE  = 3'd4,
    ST_WR_ACK   = 3'd5,
    ST_RD_BYTE  = 3'd6,
    ST_RD_ACK   = 3'd7
  } i2c_state_e;

  // Only report bytes 1..3 depend on the blob inputs; the rest are constants.
  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } blob_rec_t;

  function automatic blob_rec_t pack_blob(input logic [9:0] x, input logic [9:0] y,
                                          input logic valid, input logic [3:0] size);
    blob_rec_t r;
    if (valid) begin
      r.b1 = x[7:0];
      r.b2 = y[7:0];
      r.b3 = {y[9:8], x[9:8], size};
    end else begin
      r.b1 = NO_BLOB;
      r.b2 = NO_BLOB;
      r.b3 = NO_BLOB;
    end
    return r;
  endfunction

  function automatic logic [7:0] report_byte(input logic [IDX_W-1:0] idx, input blob_rec_t rec);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h00;
      4'd1:    b = rec.b1;
      4'd2:    b = rec.b2;
      4'd3:    b = rec.b3;
      default: b = NO_BLOB;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronises and deglitches one SCL/SDA pair and flags SCL edges plus START/STOP conditions.
module i2c_line_filter #(
  parameter int FILTER = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0]        scl_sync_r, sda_sync_r;
  logic [FILTER-1:0] scl_hist_r, sda_hist_r;
  logic              scl_flt_r, sda_flt_r, scl_prev_r, sda_prev_r;
  logic              sda_level_r, scl_rise_r, scl_fall_r, start_r, stop_r;

  // Synchroniser, sample history and filtered levels; a level is accepted only once all samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_hist_r <= '1;
      sda_hist_r <= '1;
      scl_flt_r  <= 1'b1;
      sda_flt_r  <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl};
      sda_sync_r <= {sda_sync_r[0], sda};
      scl_hist_r <= FILTER'({scl_hist_r, scl_sync_r[1]});
      sda_hist_r <= FILTER'({sda_hist_r, sda_sync_r[1]});
      if (&scl_hist_r) scl_flt_r <= 1'b1;
      else if (~|scl_hist_r) scl_flt_r <= 1'b0;
      else scl_flt_r <= scl_flt_r;
      if (&sda_hist_r) sda_flt_r <= 1'b1;
      else if (~|sda_hist_r) sda_flt_r <= 1'b0;
      else sda_flt_r <= sda_flt_r;
      scl_prev_r <= scl_flt_r;
      sda_prev_r <= sda_flt_r;
    end
  end

  // Registered edge and bus-condition strobes, aligned with the registered SDA level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_level_r <= 1'b1;
      scl_rise_r  <= 1'b0;
      scl_fall_r  <= 1'b0;
      start_r     <= 1'b0;
      stop_r      <= 1'b0;
    end else begin
      sda_level_r <= sda_flt_r;
      scl_rise_r  <= scl_flt_r & ~scl_prev_r;
      scl_fall_r  <= ~scl_flt_r & scl_prev_r;
      start_r     <= scl_flt_r & scl_prev_r & sda_prev_r & ~sda_flt_r;
      stop_r      <= scl_flt_r & scl_prev_r & ~sda_prev_r & sda_flt_r;
    end
  end

  assign sda_level = sda_level_r;
  assign scl_rise  = scl_rise_r;
  assign scl_fall  = scl_fall_r;
  assign start_det = start_r;
  assign stop_det  = stop_r;

endmodule

// File: rtl/pixart_i2c_target.sv
// I2C responder emulating the PixArt IR camera: accepts config writes and serves a 16-byte blob report.
module pixart_i2c_target
  import pixart_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR  = DEFAULT_ADDR,
  parameter int         FILTER    = 2,
  parameter logic [3:0] BLOB_SIZE = 4'h2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_out,
  output logic       i2c_sda_dir,
  input  logic [9:0] blob_x,
  input  logic [9:0] blob_y,
  input  logic       blob_valid,
  output logic       cfg_wr_en,
  output logic [7:0] cfg_wr_addr,
  output logic [7:0] cfg_wr_data,
  output logic       busy
);

  logic sda_level_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  i2c_line_filter #(.FILTER(FILTER)) u_filter (
    .clk       (clk),
    .rst_n     (reset),
    .scl       (i2c_scl),
    .sda       (i2c_sda_in),
    .sda_level (sda_level_s),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  i2c_state_e       state_r;
  logic [3:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic [7:0]       pointer_r;
  logic [IDX_W-1:0] rd_idx_r;
  blob_rec_t        rec_r;
  logic             rw_r, ack_drv_r, ptr_inc_r;
  logic             sda_dir_r, cfg_wr_en_r, busy_r;
  logic [7:0]       cfg_wr_addr_r, cfg_wr_data_r;

  logic [7:0] shift_next_s, rd_byte_s, rd_first_s;
  logic [2:0] rd_sel_s;
  logic       rd_bit_s;
  blob_rec_t  rec_now_s;

  // Datapath helpers: next shifted byte and the report bit to present on the next SCL fall.
  always_comb begin
    shift_next_s = {shift_r[6:0], sda_level_s};
    rec_now_s    = pack_blob(blob_x, blob_y, blob_valid, BLOB_SIZE);
    rd_first_s   = report_byte(4'd0, rec_now_s);
    rd_byte_s    = report_byte(rd_idx_r, rec_r);
    rd_sel_s     = 3'd7 - bit_cnt_r[2:0];
    rd_bit_s     = rd_byte_s[rd_sel_s];
  end

  // Protocol FSM; STOP and START override every state, SDA only moves on filtered SCL falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 4'd0;
      shift_r       <= 8'h00;
      pointer_r     <= 8'h00;
      rd_idx_r      <= '0;
      rec_r         <= '1;
      rw_r          <= 1'b0;
      ack_drv_r     <= 1'b0;
      ptr_inc_r     <= 1'b0;
      sda_dir_r     <= 1'b0;
      cfg_wr_en_r   <= 1'b0;
      cfg_wr_addr_r <= 8'h00;
      cfg_wr_data_r <= 8'h00;
      busy_r        <= 1'b0;
    end else begin
      cfg_wr_en_r <= 1'b0;
      if (stop_s) begin
        state_r   <= ST_IDLE;
        sda_dir_r <= 1'b0;
        busy_r    <= 1'b0;
        bit_cnt_r <= 4'd0;
        ack_drv_r <= 1'b0;
      end else if (start_s) begin
        state_r   <= ST_ADDR;
        sda_dir_r <= 1'b0;
        bit_cnt_r <= 4'd0;
        ack_drv_r <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                if (shift_next_s[7:1] == I2C_ADDR) begin
                  state_r <= ST_ADDR_ACK;
                  rw_r    <= shift_next_s[0];
                  busy_r  <= 1'b1;
                end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              if (!ack_drv_r) begin
                sda_dir_r <= 1'b1;
                ack_drv_r <= 1'b1;
              end else begin
                ack_drv_r <= 1'b0;
                // The fall that ends the ACK also presents the first report bit.
                if (rw_r) begin
                  state_r   <= ST_RD_BYTE;
                  rec_r     <= rec_now_s;
                  rd_idx_r  <= '0;
                  sda_dir_r <= ~rd_first_s[7];
                  bit_cnt_r <= 4'd1;
                end else begin
                  state_r   <= ST_PTR;
                  sda_dir_r <= 1'b0;
                  bit_cnt_r <= 4'd0;
                end
              end
            end
          end
          ST_PTR: begin
            if (scl_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r <= 4'd0;
                pointer_r <= shift_next_s;
                ptr_inc_r <= 1'b0;
                state_r   <= ST_WR_ACK;
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                bit_cnt_r     <= 4'd0;
                cfg_wr_en_r   <= 1'b1;
                cfg_wr_addr_r <= pointer_r;
                cfg_wr_data_r <= shift_next_s;
                ptr_inc_r     <= 1'b1;
                state_r       <= ST_WR_ACK;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall_s) begin
              if (!ack_drv_r) begin
                sda_dir_r <= 1'b1;
                ack_drv_r <= 1'b1;
              end else begin
                sda_dir_r <= 1'b0;
                ack_drv_r <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_WR_BYTE;
                if (ptr_inc_r) pointer_r <= pointer_r + 8'd1;
              end
            end
          end
          ST_RD_BYTE: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_dir_r <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= ST_RD_ACK;
              end else begin
                sda_dir_r <= ~rd_bit_s;
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise_s) begin
              bit_cnt_r <= 4'd0;
              sda_dir_r <= 1'b0;
              if (!sda_level_s) begin
                rd_idx_r <= rd_idx_r + 4'd1;
                state_r  <= ST_RD_BYTE;
              end else begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sda_dir_r <= 1'b0;
            busy_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda_out = 1'b0;
  assign i2c_sda_dir = sda_dir_r;
  assign cfg_wr_en   = cfg_wr_en_r;
  assign cfg_wr_addr = cfg_wr_addr_r;
  assign cfg_wr_data = cfg_wr_data_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_pixart_i2c_target.sv
// Self-checking bench: bit-banged I2C initiator with scoreboards for config writes and report reads.
module tb_pixart_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i2c_scl = 1'b1;
  logic       m_low = 1'b0;
  logic       i2c_sda_in;
  logic       i2c_sda_out, i2c_sda_dir;
  logic [9:0] blob_x = 10'd0, blob_y = 10'd0;
  logic       blob_valid = 1'b0;
  logic       cfg_wr_en, busy;
  logic [7:0] cfg_wr_addr, cfg_wr_data;

  int tests = 0;
  int fails = 0;
  logic [15:0] cfg_exp_q[$];
  logic [7:0]  rd_exp_q[$];
  logic        dir_seen = 1'b0;
  logic        dir_prev = 1'b0;
  logic        scl_prev = 1'b1;
  int          scl_high_changes = 0;

  always #5 clk = ~clk;

  assign i2c_sda_in = ~(m_low | i2c_sda_dir);

  pixart_i2c_target dut (
    .clk         (clk),
    .reset       (reset),
    .i2c_scl     (i2c_scl),
    .i2c_sda_in  (i2c_sda_in),
    .i2c_sda_out (i2c_sda_out),
    .i2c_sda_dir (i2c_sda_dir),
    .blob_x      (blob_x),
    .blob_y      (blob_y),
    .blob_valid  (blob_valid),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_addr (cfg_wr_addr),
    .cfg_wr_data (cfg_wr_data),
    .busy        (busy)
  );

  // Config-write scoreboard and SDA-while-SCL-high watcher.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (reset) begin
      if (cfg_wr_en) begin
        tests++;
        if (cfg_exp_q.size() == 0) begin
          fails++;
          $display("FAIL cfg_unexpected: got addr=%02h data=%02h, required no write", cfg_wr_addr, cfg_wr_data);
        end else begin
          exp = cfg_exp_q.pop_front();
          if ({cfg_wr_addr, cfg_wr_data} !== exp) begin
            fails++;
            $display("FAIL cfg_write: got addr=%02h data=%02h, required addr=%02h data=%02h",
                     cfg_wr_addr, cfg_wr_data, exp[15:8], exp[7:0]);
          end
        end
      end
      if (i2c_sda_dir) dir_seen = 1'b1;
      if (i2c_scl && scl_prev && (i2c_sda_dir !== dir_prev)) scl_high_changes++;
    end
    dir_prev = i2c_sda_dir;
    scl_prev = i2c_scl;
  end

  task automatic wait_q();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    if (i2c_scl == 1'b0) begin
      m_low = 1'b0;
      wait_q();
      i2c_scl = 1'b1;
    end
    wait_q();
    m_low = 1'b1;
    wait_q();
    i2c_scl = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    wait_q();
    i2c_scl = 1'b1;
    wait_q();
    m_low = 1'b0;
    wait_q();
    wait_q();
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b;
    wait_q();
    i2c_scl = 1'b1;
    wait_q();
    wait_q();
    i2c_scl = 1'b0;
    wait_q();
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0;
    wait_q();
    i2c_scl = 1'b1;
    wait_q();
    b = i2c_sda_in;
    wait_q();
    i2c_scl = 1'b0;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic check_ack(input string name, input logic got, input logic req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got ack bit %0b, required %0b", name, got, req);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({i2c_sda_dir, cfg_wr_en, busy, i2c_sda_out} !== 4'b0000 || {cfg_wr_addr, cfg_wr_data} !== 16'h0000) begin
      fails++;
      $display("FAIL reset_values: got dir=%0b en=%0b busy=%0b out=%0b addr=%02h data=%02h, required all 0",
               i2c_sda_dir, cfg_wr_en, busy, i2c_sda_out, cfg_wr_addr, cfg_wr_data);
    end
    reset = 1'b1;
    wait_q();
  endtask

  task automatic test_write();
    logic a;
    bus_start();
    write_byte(8'hB0, a);
    check_ack("wr_addr_ack", a, 1'b0);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_match: got %0b, required 1", busy); end
    write_byte(8'h30, a);
    check_ack("wr_ptr_ack", a, 1'b0);
    cfg_exp_q.push_back({8'h30, 8'h01});
    write_byte(8'h01, a);
    check_ack("wr_data0_ack", a, 1'b0);
    cfg_exp_q.push_back({8'h31, 8'h08});
    write_byte(8'h08, a);
    check_ack("wr_data1_ack", a, 1'b0);
    bus_stop();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_stop: got %0b, required 0", busy); end
    tests++;
    if (cfg_exp_q.size() != 0) begin fails++; $display("FAIL wr_missing: got %0d pending writes, required 0", cfg_exp_q.size()); end
  endtask

  task automatic test_addr_mismatch();
    logic a;
    dir_seen = 1'b0;
    bus_start();
    write_byte(8'h42, a);
    check_ack("mismatch_nack", a, 1'b1);
    write_byte(8'h55, a);
    bus_stop();
    tests++;
    if (dir_seen !== 1'b0) begin fails++; $display("FAIL mismatch_sda: got driven=%0b, required 0", dir_seen); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL mismatch_busy: got %0b, required 0", busy); end
  endtask

  task automatic do_read(input string name, input int n);
    logic [7:0] d, exp;
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1), d);
      exp = rd_exp_q.pop_front();
      tests++;
      if (d !== exp) begin
        fails++;
        $display("FAIL %s_byte%0d: got %02h, required %02h", name, i, d, exp);
      end
    end
  endtask

  task automatic test_read_blob();
    logic a;
    blob_valid = 1'b1;
    blob_x = 10'h2A5;
    blob_y = 10'h1C3;
    bus_start();
    write_byte(8'hB0, a);
    check_ack("rd1_waddr_ack", a, 1'b0);
    write_byte(8'h36, a);
    check_ack("rd1_ptr_ack", a, 1'b0);
    bus_start();
    write_byte(8'hB1, a);
    check_ack("rd1_raddr_ack", a, 1'b0);
    rd_exp_q.push_back(8'h00);
    rd_exp_q.push_back(blob_x[7:0]);
    rd_exp_q.push_back(blob_y[7:0]);
    rd_exp_q.push_back({blob_y[9:8], blob_x[9:8], 4'h2});
    do_read("rd_blob", 4);
    bus_stop();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rd1_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_read_wrap();
    logic a;
    blob_valid = 1'b0;
    bus_start();
    write_byte(8'hB1, a);
    check_ack("rd2_addr_ack", a, 1'b0);
    for (int i = 0; i < 18; i++) rd_exp_q.push_back(((i % 16) == 0) ? 8'h00 : 8'hFF);
    do_read("rd_wrap", 18);
    bus_stop();
  endtask

  task automatic test_partial_stop();
    logic a;
    bus_start();
    write_byte(8'hB0, a);
    check_ack("part_addr_ack", a, 1'b0);
    write_byte(8'h40, a);
    check_ack("part_ptr_ack", a, 1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    bus_stop();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL part_busy: got %0b, required 0", busy); end
    bus_start();
    write_byte(8'hB0, a);
    check_ack("part2_addr_ack", a, 1'b0);
    write_byte(8'h50, a);
    check_ack("part2_ptr_ack", a, 1'b0);
    cfg_exp_q.push_back({8'h50, 8'h5A});
    write_byte(8'h5A, a);
    check_ack("part2_data_ack", a, 1'b0);
    bus_stop();
    tests++;
    if (cfg_exp_q.size() != 0) begin fails++; $display("FAIL part2_missing: got %0d pending writes, required 0", cfg_exp_q.size()); end
  endtask

  task automatic test_reset_mid_ack();
    logic a;
    bus_start();
    for (int i = 7; i >= 0; i--) write_bit(logic'((8'hB0 >> i) & 8'h01));
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (i2c_sda_dir !== 1'b1) begin fails++; $display("FAIL mid_ack_drive: got dir=%0b, required 1", i2c_sda_dir); end
    reset = 1'b0;
    #1;
    tests++;
    if (i2c_sda_dir !== 1'b0) begin fails++; $display("FAIL async_release: got dir=%0b, required 0", i2c_sda_dir); end
    m_low = 1'b0;
    i2c_scl = 1'b1;
    wait_q();
    reset = 1'b1;
    wait_q();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy: got %0b, required 0", busy); end
    bus_start();
    write_byte(8'hB0, a);
    check_ack("post_reset_ack", a, 1'b0);
    bus_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read_blob();
    test_read_wrap();
    test_partial_stop();
    test_reset_mid_ack();
    tests++;
    if (scl_high_changes != 0) begin
      fails++;
      $display("FAIL sda_scl_high: got %0d SDA changes while SCL high, required 0", scl_high_changes);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
